// File: rtl/cpu_core.sv
// cpu_core: parametrised register-file CPU core.
//
// Fetches from an external combinational program ROM and executes through a
// FETCH/EXEC/WB state machine. It supports loads, ALU ops, shifts, jumps and
// HALT.
//
// Optional feature macro: CPU_MULDIV_EN
//   - Defined: MUL/DIV opcodes (7..A) are implemented.
//   - Undefined: opcodes 7..A behave as a 2-cycle NOP that sets cf. In this
//     build no multiplier or divider is inferred.
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   run       level enable, sampled only in FETCH
//   pc        address of the instruction to fetch
//   instr     ROM data for pc: {opcode[3:0], dst[RW-1:0], src[DW-1:0]}
//   dbg_sel   debug register select
//   dbg_data  register[dbg_sel], combinational
//   zf/sf/cf  zero, sign and carry/error flags
//   halted    set by HALT, cleared only by reset
module cpu_core #(
   parameter  int DW     = 8,
   parameter  int NREG   = 4,
   parameter  int IDEPTH = 16,
   localparam int RW     = $clog2(NREG),
   localparam int PW     = $clog2(IDEPTH),
   localparam int IW     = 4 + RW + DW
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          run,
   output logic [PW-1:0] pc,
   input  logic [IW-1:0] instr,
   input  logic [RW-1:0] dbg_sel,
   output logic [DW-1:0] dbg_data,
   output logic          zf,
   output logic          sf,
   output logic          cf,
   output logic          halted
);

   typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WB, S_HALT} state_t;

   typedef enum logic [3:0] {
      OP_NOP  = 4'h0, OP_LDI  = 4'h1, OP_LDR  = 4'h2, OP_ADDI = 4'h3,
      OP_ADDR = 4'h4, OP_SUBI = 4'h5, OP_SUBR = 4'h6, OP_MULI = 4'h7,
      OP_MULR = 4'h8, OP_DIVI = 4'h9, OP_DIVR = 4'hA, OP_SHR  = 4'hB,
      OP_SHL  = 4'hC, OP_JMP  = 4'hD, OP_JZ   = 4'hE, OP_HALT = 4'hF
   } opcode_t;

   typedef logic [DW-1:0] data_t;
   typedef logic [RW-1:0] ridx_t;
   typedef logic [PW-1:0] addr_t;

   // Shift amounts at or beyond the data width flush the register to zero.
   localparam data_t SH_LIM = data_t'(DW);

   state_t        state, state_next;
   logic [IW-1:0] ir;
   opcode_t       op;
   ridx_t         ir_dst;
   data_t         ir_src;
   data_t         regs [NREG];
   data_t         tmp;

   data_t         dst_val, src_val, operand, alu_res;
   logic          alu_cf;
   logic [DW:0]   sum;
`ifdef CPU_MULDIV_EN
   logic [2*DW-1:0] prod;
`endif

   logic  ir_load, pc_inc, pc_jmp, reg_we, flag_we, cf_set, tmp_we, halt_set;
   data_t reg_wdata;

   assign op       = opcode_t'(ir[IW-1:IW-4]);
   assign ir_dst   = ir[IW-5:DW];
   assign ir_src   = ir[DW-1:0];
   assign dst_val  = regs[ir_dst];
   assign src_val  = regs[ridx_t'(ir_src)];
   assign dbg_data = regs[dbg_sel];

   // ALU: dst op operand. Register-operand opcodes use the register named by
   // the low src bits; immediate opcodes use the whole src field.
   always_comb begin
      operand = ir_src;
      if (op inside {OP_ADDR, OP_SUBR, OP_MULR, OP_DIVR})
         operand = src_val;
      alu_res = '0;
      alu_cf  = 1'b0;
      sum     = '0;
`ifdef CPU_MULDIV_EN
      prod    = '0;
`endif
      case (op)
         OP_ADDI, OP_ADDR: begin
            sum     = {1'b0, dst_val} + {1'b0, operand};
            alu_res = sum[DW-1:0];
            alu_cf  = sum[DW];
         end
         OP_SUBI, OP_SUBR: begin
            alu_res = dst_val - operand;
            alu_cf  = (dst_val < operand);
         end
`ifdef CPU_MULDIV_EN
         OP_MULI, OP_MULR: begin
            prod    = {{DW{1'b0}}, dst_val} * {{DW{1'b0}}, operand};
            alu_res = prod[DW-1:0];
            alu_cf  = |prod[2*DW-1:DW];
         end
         OP_DIVI, OP_DIVR: begin
            if (operand == '0) begin
               alu_res = '1;
               alu_cf  = 1'b1;
            end else begin
               alu_res = dst_val / operand;
            end
         end
`endif
         OP_SHR:  alu_res = (ir_src >= SH_LIM) ? '0 : (dst_val >> ir_src);
         OP_SHL:  alu_res = (ir_src >= SH_LIM) ? '0 : (dst_val << ir_src);
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_FETCH;
      else        state <= state_next;
   end

   always_comb begin
      state_next = state;
      ir_load    = 1'b0;
      pc_inc     = 1'b0;
      pc_jmp     = 1'b0;
      reg_we     = 1'b0;
      reg_wdata  = alu_res;
      flag_we    = 1'b0;
      cf_set     = 1'b0;
      tmp_we     = 1'b0;
      halt_set   = 1'b0;
      case (state)
         S_FETCH: begin
            if (run) begin
               ir_load    = 1'b1;
               state_next = S_EXEC;
            end
         end
         S_EXEC: begin
            state_next = S_FETCH;
            case (op)
               OP_NOP: pc_inc = 1'b1;
               OP_LDI: begin
                  reg_we    = 1'b1;
                  reg_wdata = ir_src;
                  pc_inc    = 1'b1;
               end
               OP_LDR: begin
                  reg_we    = 1'b1;
                  reg_wdata = src_val;
                  pc_inc    = 1'b1;
               end
               OP_ADDI, OP_ADDR, OP_SUBI, OP_SUBR: begin
                  tmp_we     = 1'b1;
                  flag_we    = 1'b1;
                  state_next = S_WB;
               end
               OP_MULI, OP_MULR, OP_DIVI, OP_DIVR: begin
`ifdef CPU_MULDIV_EN
                  tmp_we     = 1'b1;
                  flag_we    = 1'b1;
                  state_next = S_WB;
`else
                  cf_set = 1'b1;
                  pc_inc = 1'b1;
`endif
               end
               OP_SHR, OP_SHL: begin
                  reg_we  = 1'b1;
                  flag_we = 1'b1;
                  pc_inc  = 1'b1;
               end
               OP_JMP: pc_jmp = 1'b1;
               OP_JZ: begin
                  if (zf) pc_jmp = 1'b1;
                  else    pc_inc = 1'b1;
               end
               OP_HALT: begin
                  halt_set   = 1'b1;
                  state_next = S_HALT;
               end
               default: pc_inc = 1'b1;
            endcase
         end
         S_WB: begin
            reg_we     = 1'b1;
            reg_wdata  = tmp;
            pc_inc     = 1'b1;
            state_next = S_FETCH;
         end
         S_HALT:  state_next = S_HALT;
         default: state_next = S_FETCH;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ir     <= '0;
         tmp    <= '0;
         pc     <= '0;
         zf     <= 1'b0;
         sf     <= 1'b0;
         cf     <= 1'b0;
         halted <= 1'b0;
         for (int unsigned i = 0; i < NREG; i++) regs[ridx_t'(i)] <= '0;
      end else begin
         if (ir_load) ir  <= instr;
         if (tmp_we)  tmp <= alu_res;
         if (reg_we)  regs[ir_dst] <= reg_wdata;
         if (flag_we) begin
            zf <= (alu_res == '0);
            sf <= alu_res[DW-1];
            cf <= alu_cf;
         end
         if (cf_set) cf <= 1'b1;
         if (pc_jmp)      pc <= addr_t'(ir_src);
         else if (pc_inc) pc <= pc + 1'b1;
         if (halt_set) halted <= 1'b1;
      end
   end

endmodule
